// File: rtl/eight_bit_sync_counter_core_if.sv
// Control/data bundle for eight_bit_sync_counter_core.
// The master drives the load request, output enable and preset value.
// The slave (the counter core) returns the gated count.
interface eight_bit_sync_counter_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic             out_en;
  logic [WIDTH-1:0] base_count;
  logic [WIDTH-1:0] counter_state;

  modport master (
    output load,
    output out_en,
    output base_count,
    input  counter_state
  );

  modport slave (
    input  load,
    input  out_en,
    input  base_count,
    output counter_state
  );
endinterface

// File: rtl/eight_bit_sync_counter_core.sv
// Free-running synchronous up-counter with parallel load and output gating.
// rst is synchronous and active-low. Each edge applies reset first, then load, then increment.
// Optional macro COUNTER_OUT_REG_EN registers the gated output, which removes the
// combinational path from out_en to counter_state. The default build (macro undefined)
// drives the gated output combinationally from the count register.
module eight_bit_sync_counter_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  eight_bit_sync_counter_core_if.slave   bus_io
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: reset beats load, and load beats increment. Wrap is natural modulo 2^WIDTH.
  always_comb begin
    count_d = count_q;
    if (!rst) begin
      count_d = '0;
    end else if (bus_io.load) begin
      count_d = bus_io.base_count;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register. The synchronous reset is folded into count_d.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

`ifdef COUNTER_OUT_REG_EN
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Registered view: gate the value count takes on this edge. count_d is zero under reset,
  // so the output register clears on the same edge as count.
  always_comb begin
    out_d = bus_io.out_en ? count_d : '0;
  end

  // Output register
  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign bus_io.counter_state = out_q;
`else
  // Combinational view: gating only masks the output and never touches the count.
  always_comb begin
    bus_io.counter_state = bus_io.out_en ? count_q : '0;
  end
`endif

endmodule

// File: tb/tb_eight_bit_sync_counter_core.sv
// Directed self-checking bench for eight_bit_sync_counter_core.
// Inputs change #1 after a rising edge, and outputs are sampled at that same point.
module tb_eight_bit_sync_counter_core;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  eight_bit_sync_counter_core_if #(.WIDTH(8)) bus ();

  eight_bit_sync_counter_core #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h01; exp_v[1] = 8'h02; exp_v[2] = 8'h03;
    rst = 1'b0; bus.load = 1'b1; bus.base_count = 8'hA5; bus.out_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.counter_state !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %h want 00", i, bus.counter_state);
      end
    end
    rst = 1'b1; bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.counter_state !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_release[%0d] got %h want %h", i, bus.counter_state, exp_v[i]);
      end
    end
  endtask

  task automatic test_load();
    bus.load = 1'b1; bus.base_count = 8'h3C;
    step();
    checks++;
    if (bus.counter_state !== 8'h3C) begin
      errors++;
      $display("FAIL load got %h want 3c", bus.counter_state);
    end
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.counter_state !== 8'h3D) begin
      errors++;
      $display("FAIL load_inc1 got %h want 3d", bus.counter_state);
    end
    step();
    checks++;
    if (bus.counter_state !== 8'h3E) begin
      errors++;
      $display("FAIL load_inc2 got %h want 3e", bus.counter_state);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v [4];
    exp_v[0] = 8'hFE; exp_v[1] = 8'hFF; exp_v[2] = 8'h00; exp_v[3] = 8'h01;
    bus.load = 1'b1; bus.base_count = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.counter_state !== exp_v[i]) begin
        errors++;
        $display("FAIL wrap[%0d] got %h want %h", i, bus.counter_state, exp_v[i]);
      end
    end
  endtask

  task automatic test_gating();
    logic [7:0] exp_mid;
    bus.load = 1'b1; bus.base_count = 8'h10;
    step();
    bus.load = 1'b0; bus.out_en = 1'b0;
    #1;
`ifdef COUNTER_OUT_REG_EN
    exp_mid = 8'h10;
`else
    exp_mid = 8'h00;
`endif
    checks++;
    if (bus.counter_state !== exp_mid) begin
      errors++;
      $display("FAIL gate_off_immediate got %h want %h", bus.counter_state, exp_mid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.counter_state !== 8'h00) begin
        errors++;
        $display("FAIL gated[%0d] got %h want 00", i, bus.counter_state);
      end
    end
    // The count has reached 0x13 while the output is masked.
    bus.out_en = 1'b1;
    #1;
`ifdef COUNTER_OUT_REG_EN
    exp_mid = 8'h00;
`else
    exp_mid = 8'h13;
`endif
    checks++;
    if (bus.counter_state !== exp_mid) begin
      errors++;
      $display("FAIL gate_on_immediate got %h want %h", bus.counter_state, exp_mid);
    end
    step();
    checks++;
    if (bus.counter_state !== 8'h14) begin
      errors++;
      $display("FAIL gate_restore got %h want 14", bus.counter_state);
    end
  endtask

  task automatic test_priority();
    rst = 1'b0; bus.load = 1'b1; bus.base_count = 8'h77;
    step();
    checks++;
    if (bus.counter_state !== 8'h00) begin
      errors++;
      $display("FAIL prio_reset got %h want 00", bus.counter_state);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.counter_state !== 8'h77) begin
      errors++;
      $display("FAIL prio_release_load got %h want 77", bus.counter_state);
    end
    bus.load = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.load = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.base_count = 8'(i);
      step();
      checks++;
      if (bus.counter_state !== 8'(i)) begin
        errors++;
        $display("FAIL sustained_load[%0d] got %h want %h", i, bus.counter_state, 8'(i));
      end
    end
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.counter_state !== 8'h05) begin
      errors++;
      $display("FAIL sustained_release got %h want 05", bus.counter_state);
    end
    // A load pulse that lands between edges must be ignored.
    #2;
    bus.load = 1'b1; bus.base_count = 8'hC3;
    #2;
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.counter_state !== 8'h06) begin
      errors++;
      $display("FAIL load_glitch got %h want 06", bus.counter_state);
    end
  endtask

  // Stop a stuck run with a failure rather than hanging.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.load = 1'b0;
    bus.out_en = 1'b1;
    bus.base_count = 8'h00;
    #1;
    test_reset();
    test_load();
    test_wrap();
    test_gating();
    test_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eight_bit_sync_counter_core.md
# eight_bit_sync_counter_core

Free-running 8-bit synchronous up-counter with a parallel load and output gating. It sits in the user-project area as a simple count and timestamp source. Software or the pin interface can preset it to any base value. Its visible state can be masked to zero without disturbing the count.

## Interface
Parameters:
- WIDTH, 8, counter and data width; all tests run at 8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low; sampled on the rising clk edge; clears the counter when 0.
- load  input  1  synchronous parallel-load request, active-high.
- out_en  input  1  output enable, active-high; gates counter_state.
- base_count  input  WIDTH  value loaded into the counter when load=1.
- counter_state  output  WIDTH  gated view of the internal count.

## Operation
- Internal register `count[WIDTH-1:0]`.
- Per rising edge, in priority order:
  - rst=0: count <= 0. Overrides load and counting.
  - rst=1, load=1: count <= base_count.
  - rst=1, load=0: count <= count + 1, modulo 2^WIDTH.
- Counting is unconditional: no count-enable exists, and out_en never stalls or alters count.
- Wrap-around: 0xFF + 1 = 0x00, with no flag and no stall.
- Output gating: out_en=1 drives count onto counter_state; out_en=0 forces counter_state to all zeros.
  - The output is never tri-stated.
- load and base_count are sampled only on the clock edge; glitches between edges have no effect.
- load held high for N cycles reloads base_count every cycle, so count stays equal to the current base_count.
- No X propagation: count is always defined after the first edge with rst=0.

## Timing
- Reset: count=0 from the first rising edge sampled with rst=0.
  - counter_state=0 from that edge regardless of out_en; the default build also needs out_en=1 for the zero to come from count rather than from gating.
  - Before the first reset edge, count is undefined; the bench must reset first.
- Load latency: count=base_count immediately after the edge where load=1. Counting resumes on the next edge: base_count+1 one cycle later.
- Increment: one step per clock.
- out_en latency (default build): combinational; counter_state follows out_en in the same cycle.
- Reset mid-count or mid-load: reset wins on that edge. Counting resumes from 0 on the first edge with rst=1 and load=0; that edge yields 1.
- Release of reset with load=1 on the same edge: count=base_count after that edge.

## Configuration
- Macro: `COUNTER_OUT_REG_EN`.
- Undefined (default):
  - counter_state = out_en ? count : 0, purely combinational from the register and out_en.
  - Zero-cycle latency from count and out_en to counter_state.
- Defined:
  - counter_state is itself a register loaded each rising edge with (out_en ? next_count : 0), where next_count is the value count takes on that edge.
  - counter_state therefore equals the gated count value after the edge, with no combinational path from out_en to the output.
  - The effect of an out_en change appears one edge later.
  - Reset (rst=0) clears the output register to 0 on the same edge as count.

## Test plan
- Reset: rst=0 for 2 cycles with load=1, base_count=0xA5, out_en=1 -> counter_state=0x00. Release rst with load=0 -> 0x01, 0x02, 0x03 on successive edges.
- Load: load=1, base_count=0x3C for one edge -> counter_state=0x3C. Drop load -> 0x3D, then 0x3E.
- Wrap: load 0xFE, then count -> 0xFE, 0xFF, 0x00, 0x01. No stall or glitch at the wrap.
- Output gating: count running from 0x10; out_en=0 for 3 edges -> counter_state=0x00 while gated. Restore out_en=1 -> 0x14, proving counting continued. With COUNTER_OUT_REG_EN, the output change lags out_en by one edge.
- Priority: rst=0 and load=1 with base_count=0x77 on the same edge -> 0x00. rst=1 and load=1 on the next edge -> 0x77.
- Sustained load: load=1 for 4 edges while base_count steps 0x01, 0x02, 0x03, 0x04 -> counter_state tracks each value one edge after it is applied, with no increment.
